// File: rtl/source_sequencer.sv
// Frame sequencer for the SOURCE excitation generator: valid/ready frame intake,
// sample-strobe divider, and per-frame period/amplitude presentation. Macro: SOURCE_PITCHSYNC_EN.
module source_sequencer #(
    parameter int CLK_DIV = 5,
    parameter int DUR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_period,
    input  logic [14:0]      in_amp,
    input  logic [DUR_W-1:0] in_dur,
    input  logic             period_done,
    output logic             strobe,
    output logic [7:0]       period,
    output logic [14:0]      amplitude,
    output logic             busy,
    output logic             underrun
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } StateType;

    StateType r_state;
    StateType w_nextState;

    logic [DIV_W-1:0] r_div;
    logic [DUR_W-1:0] r_remaining;
    logic [7:0]       r_period;
    logic [14:0]      r_amplitude;
    logic             r_underrun;

    logic             r_pendValid;
    logic [7:0]       r_pendPeriod;
    logic [14:0]      r_pendAmp;
    logic [DUR_W-1:0] r_pendDur;

    logic             w_strobe;
    logic             w_accept;
    logic             w_loadIn;
    logic             w_loadPend;
    logic             w_load;
    logic             w_storePend;
    logic             w_decr;
    logic             w_stop;
    logic [DUR_W-1:0] w_inDur;
    logic [7:0]       w_newPeriod;
    logic [14:0]      w_newAmp;
    logic [DUR_W-1:0] w_newDur;

    assign w_strobe    = (r_div == DIV_LAST);
    assign w_accept    = in_valid && !r_pendValid;
    assign w_inDur     = (in_dur == '0) ? DUR_W'(1) : in_dur;
    assign w_load      = w_loadIn || w_loadPend;
    assign w_newPeriod = w_loadPend ? r_pendPeriod : in_period;
    assign w_newAmp    = w_loadPend ? r_pendAmp : in_amp;
    assign w_newDur    = w_loadPend ? r_pendDur : w_inDur;

    assign in_ready  = !r_pendValid;
    assign strobe    = w_strobe;
    assign period    = r_period;
    assign amplitude = r_amplitude;
    assign busy      = (r_state == PLAY);
    assign underrun  = r_underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_strobe) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // At frame end a pending frame wins, then a frame offered that very cycle.
    always_comb begin
        w_nextState = r_state;
        w_loadIn    = 1'b0;
        w_loadPend  = 1'b0;
        w_storePend = 1'b0;
        w_decr      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_loadIn    = 1'b1;
                    w_nextState = PLAY;
                end
            end
            PLAY: begin
                if (w_strobe && (r_remaining == DUR_W'(1))) begin
                    if (r_pendValid) begin
                        w_loadPend = 1'b1;
                    end else if (in_valid) begin
                        w_loadIn = 1'b1;
                    end else begin
                        w_stop      = 1'b1;
                        w_nextState = IDLE;
                    end
                end else begin
                    w_decr      = w_strobe;
                    w_storePend = w_accept;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_amplitude <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= w_stop;
            if (w_load) begin
                r_amplitude <= w_newAmp;
                r_remaining <= w_newDur;
            end else if (w_stop) begin
                r_amplitude <= '0;
            end else if (w_decr) begin
                r_remaining <= r_remaining - DUR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendValid  <= 1'b0;
            r_pendPeriod <= '0;
            r_pendAmp    <= '0;
            r_pendDur    <= '0;
        end else if (w_storePend) begin
            r_pendValid  <= 1'b1;
            r_pendPeriod <= in_period;
            r_pendAmp    <= in_amp;
            r_pendDur    <= w_inDur;
        end else if (w_loadPend) begin
            r_pendValid <= 1'b0;
        end
    end

`ifdef SOURCE_PITCHSYNC_EN
    logic [7:0] r_periodNext;
    logic       r_pitchFlag;

    // Voiced-to-voiced pitch changes wait for the glottal-period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period     <= '0;
            r_periodNext <= '0;
            r_pitchFlag  <= 1'b0;
        end else if (w_load) begin
            if ((r_state == PLAY) && (r_period != 8'd0) && (w_newPeriod != 8'd0)) begin
                r_periodNext <= w_newPeriod;
                r_pitchFlag  <= 1'b1;
            end else begin
                r_period    <= w_newPeriod;
                r_pitchFlag <= 1'b0;
            end
        end else if (period_done && r_pitchFlag) begin
            r_period    <= r_periodNext;
            r_pitchFlag <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = period_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
        end else if (w_load) begin
            r_period <= w_newPeriod;
        end
    end
`endif

endmodule

// File: tb/tb_source_sequencer.sv
// Directed self-checking bench for source_sequencer (CLK_DIV=5, DUR_W=8);
// period expectations follow SOURCE_PITCHSYNC_EN when it is defined.
module tb_source_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_period = '0;
    logic [14:0] in_amp = '0;
    logic [7:0]  in_dur = '0;
    logic        period_done = 1'b0;
    logic        strobe;
    logic [7:0]  period;
    logic [14:0] amplitude;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int strobeCnt = 0;

`ifdef SOURCE_PITCHSYNC_EN
    localparam bit PITCHSYNC = 1'b1;
`else
    localparam bit PITCHSYNC = 1'b0;
`endif

    source_sequencer #(.CLK_DIV(5), .DUR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_period(in_period), .in_amp(in_amp), .in_dur(in_dur),
        .period_done(period_done), .strobe(strobe), .period(period),
        .amplitude(amplitude), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Advance one clock, noting whether the edge just taken was a strobe edge.
    task automatic step();
        if (strobe === 1'b1) strobeCnt++;
        @(negedge clk);
    endtask

    task automatic waitStrobes(input int n, input string tag);
        int g;
        g = 0;
        while (strobeCnt < n && g < 60) begin
            step();
            g++;
        end
        checks++;
        if (strobeCnt < n) begin
            errors++;
            $display("[TB] FAIL %s_timeout strobes seen %0d need %0d", tag, strobeCnt, n);
        end
    endtask

    task automatic offer(input logic [7:0] p, input logic [14:0] a, input logic [7:0] d);
        in_valid  = 1'b1;
        in_period = p;
        in_amp    = a;
        in_dur    = d;
    endtask

    task automatic test_reset();
        logic expS;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (strobe !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobe got %b exp 0", strobe); end
        checks++; if (period !== 8'd0) begin errors++; $display("[TB] FAIL rst_period got %0d exp 0", period); end
        checks++; if (amplitude !== 15'd0) begin errors++; $display("[TB] FAIL rst_amp got %0d exp 0", amplitude); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_underrun got %b exp 0", underrun); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            expS = ((k % 5) == 4);
            checks++;
            if (strobe !== expS) begin
                errors++;
                $display("[TB] FAIL rst_strobe_phase%0d got %b exp %b", k, strobe, expS);
            end
        end
    endtask

    task automatic test_single_frame();
        offer(8'd50, 15'd15000, 8'd4);
        step();
        in_valid  = 1'b0;
        strobeCnt = 0;
        checks++; if (period !== 8'd50) begin errors++; $display("[TB] FAIL t2_period got %0d exp 50", period); end
        checks++; if (amplitude !== 15'd15000) begin errors++; $display("[TB] FAIL t2_amp got %0d exp 15000", amplitude); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t2_busy got %b exp 1", busy); end
        waitStrobes(3, "t2_s3");
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t2_busy_s3 got %b exp 1", busy); end
        checks++; if (amplitude !== 15'd15000) begin errors++; $display("[TB] FAIL t2_amp_s3 got %0d exp 15000", amplitude); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL t2_underrun_s3 got %b exp 0", underrun); end
        waitStrobes(4, "t2_s4");
        checks++; if (amplitude !== 15'd0) begin errors++; $display("[TB] FAIL t2_amp_end got %0d exp 0", amplitude); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_busy_end got %b exp 0", busy); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL t2_underrun_end got %b exp 1", underrun); end
        checks++; if (period !== 8'd50) begin errors++; $display("[TB] FAIL t2_period_held got %0d exp 50", period); end
        step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL t2_underrun_pulse got %b exp 0", underrun); end
    endtask

    task automatic test_pending();
        logic [7:0] expP;
        offer(8'd50, 15'd1000, 8'd3);
        step();
        strobeCnt = 0;
        offer(8'd80, 15'd2000, 8'd2);
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL t3_in_ready_pend got %b exp 0", in_ready); end
        checks++; if (period !== 8'd50) begin errors++; $display("[TB] FAIL t3_period_a got %0d exp 50", period); end
        checks++; if (amplitude !== 15'd1000) begin errors++; $display("[TB] FAIL t3_amp_a got %0d exp 1000", amplitude); end
        waitStrobes(3, "t3_a_end");
        strobeCnt = 0;
        expP = PITCHSYNC ? 8'd50 : 8'd80;
        checks++; if (amplitude !== 15'd2000) begin errors++; $display("[TB] FAIL t3_amp_b got %0d exp 2000", amplitude); end
        checks++; if (period !== expP) begin errors++; $display("[TB] FAIL t3_period_b got %0d exp %0d", period, expP); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL t3_in_ready_b got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b1 || underrun !== 1'b0) begin errors++; $display("[TB] FAIL t3_busy_underrun got %b%b exp 10", busy, underrun); end
        period_done = 1'b1;
        step();
        period_done = 1'b0;
        checks++; if (period !== 8'd80) begin errors++; $display("[TB] FAIL t3_period_done got %0d exp 80", period); end
        waitStrobes(2, "t3_b_end");
        checks++; if (busy !== 1'b0 || underrun !== 1'b1) begin errors++; $display("[TB] FAIL t3_end got busy %b underrun %b exp 0 1", busy, underrun); end
        checks++; if (amplitude !== 15'd0) begin errors++; $display("[TB] FAIL t3_amp_end got %0d exp 0", amplitude); end
        step();
    endtask

    task automatic test_noise();
        offer(8'd50, 15'd1000, 8'd2);
        step();
        strobeCnt = 0;
        checks++; if (period !== 8'd50) begin errors++; $display("[TB] FAIL t4_period_a got %0d exp 50", period); end
        offer(8'd0, 15'd500, 8'd2);
        step();
        in_valid    = 1'b0;
        period_done = 1'b1;
        step();
        period_done = 1'b0;
        checks++; if (period !== 8'd50) begin errors++; $display("[TB] FAIL t4_done_ignored got %0d exp 50", period); end
        waitStrobes(2, "t4_a_end");
        strobeCnt = 0;
        checks++; if (period !== 8'd0) begin errors++; $display("[TB] FAIL t4_period_b got %0d exp 0", period); end
        checks++; if (amplitude !== 15'd500) begin errors++; $display("[TB] FAIL t4_amp_b got %0d exp 500", amplitude); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t4_busy_b got %b exp 1", busy); end
        waitStrobes(2, "t4_b_end");
        checks++; if (busy !== 1'b0 || underrun !== 1'b1) begin errors++; $display("[TB] FAIL t4_end got busy %b underrun %b exp 0 1", busy, underrun); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] expP;
        int g;
        offer(8'd60, 15'd700, 8'd0);
        step();
        in_valid = 1'b0;
        checks++; if (amplitude !== 15'd700 || period !== 8'd60) begin errors++; $display("[TB] FAIL t5_load got %0d/%0d exp 60/700", period, amplitude); end
        g = 0;
        while (strobe !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        checks++; if (strobe !== 1'b1) begin errors++; $display("[TB] FAIL t5_strobe_timeout got %b exp 1", strobe); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t5_busy_before got %b exp 1", busy); end
        offer(8'd90, 15'd1200, 8'd1);
        step();
        in_valid  = 1'b0;
        strobeCnt = 0;
        expP = PITCHSYNC ? 8'd60 : 8'd90;
        checks++; if (amplitude !== 15'd1200) begin errors++; $display("[TB] FAIL t5_amp_bypass got %0d exp 1200", amplitude); end
        checks++; if (period !== expP) begin errors++; $display("[TB] FAIL t5_period_bypass got %0d exp %0d", period, expP); end
        checks++; if (busy !== 1'b1 || underrun !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_underrun got busy %b underrun %b exp 1 0", busy, underrun); end
        step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_underrun2 got %b exp 0", underrun); end
        waitStrobes(1, "t5_c_end");
        checks++; if (busy !== 1'b0 || underrun !== 1'b1) begin errors++; $display("[TB] FAIL t5_end got busy %b underrun %b exp 0 1", busy, underrun); end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic expS;
        offer(8'd50, 15'd1000, 8'd5);
        step();
        offer(8'd70, 15'd900, 8'd3);
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL t6_pend_full got %b exp 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (amplitude !== 15'd0 || period !== 8'd0) begin errors++; $display("[TB] FAIL t6_async_out got %0d/%0d exp 0/0", period, amplitude); end
        checks++; if (busy !== 1'b0 || underrun !== 1'b0) begin errors++; $display("[TB] FAIL t6_async_flags got busy %b underrun %b exp 0 0", busy, underrun); end
        checks++; if (in_ready !== 1'b1 || strobe !== 1'b0) begin errors++; $display("[TB] FAIL t6_async_ready got in_ready %b strobe %b exp 1 0", in_ready, strobe); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            expS = ((k % 5) == 4);
            checks++;
            if (strobe !== expS || busy !== 1'b0 || underrun !== 1'b0) begin
                errors++;
                $display("[TB] FAIL t6_post%0d got strobe %b busy %b underrun %b exp %b 0 0", k, strobe, busy, underrun, expS);
            end
        end
    endtask

    initial begin
        $display("[TB] source_sequencer bench start (pitchsync=%0d)", PITCHSYNC);
        test_reset();
        test_single_frame();
        test_pending();
        test_noise();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got running exp finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
